frame_byte_reader: RTL and testbench
====================================

// Module: frame_byte_reader
// PURPOSE
// Readback counterpart of the pixel/byte capture writer. On start, fetches 16-bit words from SRAM at
// consecutive word addresses, unpacks each into two bytes (low byte first, matching write packing),
// streams them downstream over a valid/ready handshake, and stops after the end-of-image word.
// Sits between the SRAM controller and the frame send path (UART/SPI transmitter).
// PARAMETERS
// EOI_WORD   16'hFFD9  raw SRAM word that terminates the frame (same compare as the writer)
// MAX_WORDS  32768     words read without seeing EOI_WORD before error
// TIMEOUT    255       max cycles in one SRAM wait state before error (8-bit counter)
// PORTS
// clk          in   1   system clock, all logic on rising edge
// reset        in   1   synchronous, active-high
// start        in   1   level; sampled only in IDLE, begins a frame readout
// base_addr    in   16  first SRAM word address, latched on start
// sram_ready   in   1   SRAM controller idle/done (1 = ready)
// sram_rdata   in   16  read data, valid when sram_ready rises after a request
// sram_addr    out  16  SRAM word address
// sram_we      out  1   constant 1 (read); controller writes on 0
// sram_start   out  1   active-low one-cycle request strobe
// byte_data    out  8   output byte
// byte_valid   out  1   byte_data valid
// byte_ready   in   1   downstream accepts; transfer when byte_valid && byte_ready at clk edge
// busy         out  1   1 in any state except IDLE
// frame_done   out  1   one-cycle pulse after last byte of EOI word transferred
// error        out  1   sticky; set on timeout or MAX_WORDS overrun; cleared on next accepted start or reset
// BEHAVIOUR
// Reset (sync, any state, aborts in-flight read): state=IDLE, sram_addr=0, sram_start=1, byte_data=0,
//   byte_valid=0, busy=0, frame_done=0, error=0, word count=0, wait counter=0. sram_we always 1.
// FSM: IDLE -> REQ -> WAIT_BUSY -> WAIT_DONE -> SEND_LO -> SEND_HI -> (NEXT -> REQ | DONE -> IDLE)
// IDLE: start=1 -> sram_addr<=base_addr, word count<=0, error<=0, go REQ. start while busy ignored.
// REQ: sram_start=0 for exactly this one cycle; go WAIT_BUSY. Latency start->sram_start low = 1 cycle.
// WAIT_BUSY: wait sram_ready=0 (request taken); WAIT_DONE: wait sram_ready=1, then latch sram_rdata.
//   Never sample data on a stale ready. Wait counter reset on each state entry; reaching TIMEOUT in
//   either wait state -> error<=1, go IDLE (no frame_done).
// SEND_LO: byte_valid=1, byte_data=word[7:0]; hold data stable until byte_ready; on transfer go SEND_HI.
// SEND_HI: byte_data=word[15:8]; on transfer: if word==EOI_WORD go DONE, else go NEXT.
// Back-to-back transfers allowed: byte_valid stays 1 across SEND_LO->SEND_HI when byte_ready held 1.
// byte_valid=0 in all other states; no byte ever dropped or duplicated under backpressure.
// NEXT: sram_addr<=sram_addr+1 (wraps FFFF->0000), count+1; count reaching MAX_WORDS -> error<=1, IDLE.
// DONE: frame_done=1 for one cycle, go IDLE. Both bytes of the EOI word are always emitted.
// Simultaneous start with reset: reset wins. byte_ready ignored when byte_valid=0.
// Min throughput (ready always 1, SRAM 1-cycle): REQ,WAIT_BUSY,WAIT_DONE,SEND_LO,SEND_HI,NEXT = 6 cycles/word.
// TESTING
// 1. SRAM model holds 0x2211,0x4433,0xFFD9 at base 0x0010, byte_ready=1, start pulse -> bytes
//    11,22,33,44,D9,FF in order, sram_addr 0x10..0x12, frame_done single pulse, error=0, busy low after.
// 2. Same data, byte_ready toggled 1/0 every cycle and held 0 for 5 cycles mid-SEND_HI -> identical
//    byte sequence, byte_data stable while valid&&!ready, no duplicates.
// 3. SRAM model never raises sram_ready after request -> error=1 after TIMEOUT(255) cycles, IDLE,
//    no frame_done, no byte_valid; next start clears error.
// 4. base_addr=0xFFFF, data 0xAABB then 0xFFD9 at 0x0000 -> address wraps to 0x0000, bytes BB,AA,D9,FF.
// 5. reset asserted while in SEND_HI with byte_valid=1 -> next cycle all outputs at reset values;
//    new start reads from base_addr afresh.
// 6. Memory with no EOI word, MAX_WORDS=4 override -> 8 bytes emitted, then error=1, no frame_done.

Source files
------------

// File: rtl/frame_byte_reader.sv
// -----------------------------------------------------------------------------
// frame_byte_reader
//
// Reads back a captured frame from SRAM. It fetches 16-bit words at
// consecutive word addresses starting from base_addr and unpacks each word
// into two bytes, low byte first. This matches the packing used by the
// capture writer. The bytes are streamed downstream over a valid/ready
// handshake. Readout stops after both bytes of the end-of-image word have
// been sent.
//
// Ports
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high
//   start       in   1   level, sampled only while idle; begins a readout
//   base_addr   in  16   first SRAM word address, latched on start
//   sram_ready  in   1   SRAM controller idle/done
//   sram_rdata  in  16   read data, valid when sram_ready rises after a request
//   sram_addr   out 16   SRAM word address
//   sram_we     out  1   tied high (this block only reads)
//   sram_start  out  1   active-low one-cycle request strobe
//   byte_data   out  8   output byte
//   byte_valid  out  1   byte_data valid
//   byte_ready  in   1   downstream accepts the byte
//   busy        out  1   high whenever not idle
//   frame_done  out  1   one-cycle pulse after the last EOI byte is taken
//   error       out  1   sticky timeout / word-overrun flag
// -----------------------------------------------------------------------------
module frame_byte_reader #(
  parameter logic [15:0] EOI_WORD  = 16'hFFD9,
  parameter int          MAX_WORDS = 32768,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] base_addr,
  input  logic        sram_ready,
  input  logic [15:0] sram_rdata,
  output logic [15:0] sram_addr,
  output logic        sram_we,
  output logic        sram_start,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        busy,
  output logic        frame_done,
  output logic        error
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_REQ       = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_SEND_LO   = 3'd4;
  localparam logic [2:0] ST_SEND_HI   = 3'd5;
  localparam logic [2:0] ST_NEXT      = 3'd6;
  localparam logic [2:0] ST_DONE      = 3'd7;

  localparam int         CW        = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WORDS);
  // The wait counter starts at 0 on entry to a wait state. When it reaches
  // this value, the state has already lasted TIMEOUT cycles.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    wait_q, wait_d;
  logic          error_q, error_d;
  logic [CW-1:0] cnt_inc;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    error_d = error_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          cnt_d   = '0;
          error_d = 1'b0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        wait_d  = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // The controller must first drop ready. This shows that it accepted
        // the request, so a ready left over from the previous access is
        // never mistaken for completion.
        if (!sram_ready) begin
          wait_d  = '0;
          state_d = ST_WAIT_DONE;
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WAIT_DONE: begin
        if (sram_ready) begin
          word_d  = sram_rdata;
          state_d = ST_SEND_LO;
        end else if (wait_q == WAIT_LAST) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_SEND_LO: begin
        if (byte_ready) state_d = ST_SEND_HI;
      end
      ST_SEND_HI: begin
        if (byte_ready) state_d = (word_q == EOI_WORD) ? ST_DONE : ST_NEXT;
      end
      ST_NEXT: begin
        addr_d = addr_q + 16'd1;
        cnt_d  = cnt_inc;
        if (cnt_inc == CNT_MAX) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  // The outputs are decoded from the registered state, so they are glitch-free
  // and return to their idle values in the cycle after reset.
  assign sram_addr  = addr_q;
  assign sram_we    = 1'b1;
  assign sram_start = (state_q != ST_REQ);
  assign byte_valid = (state_q == ST_SEND_LO) || (state_q == ST_SEND_HI);
  assign byte_data  = (state_q == ST_SEND_LO) ? word_q[7:0]  :
                      (state_q == ST_SEND_HI) ? word_q[15:8] : 8'h00;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign error      = error_q;

endmodule

// File: tb/tb_frame_byte_reader.sv
// -----------------------------------------------------------------------------
// Testbench for frame_byte_reader. It uses a behavioural SRAM model with
// random latency, a downstream ready generator and a byte monitor. Expected
// byte streams and outcomes come from a frame-level reference model.
// -----------------------------------------------------------------------------
module tb_frame_byte_reader;

  localparam int          MAXW = 4;
  localparam logic [15:0] EOI  = 16'hFFD9;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'h0000;
  logic        sram_ready;
  logic [15:0] sram_rdata;
  logic [15:0] sram_addr;
  logic        sram_we;
  logic        sram_start;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready = 1'b0;
  logic        busy;
  logic        frame_done;
  logic        error;

  frame_byte_reader #(.EOI_WORD(EOI), .MAX_WORDS(MAXW), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .sram_ready(sram_ready), .sram_rdata(sram_rdata), .sram_addr(sram_addr),
    .sram_we(sram_we), .sram_start(sram_start), .byte_data(byte_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
    .frame_done(frame_done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- SRAM model ----------------
  logic [15:0] mem [0:65535];
  int          lat_max = 0;
  bit          sram_dead = 1'b0;
  logic        pend;
  int          lat_cnt;
  logic [15:0] req_a;

  always @(posedge clk) begin
    if (reset) begin
      sram_ready <= 1'b1;
      pend       <= 1'b0;
      sram_rdata <= 16'h0000;
    end else if (!sram_start) begin
      sram_ready <= 1'b0;
      pend       <= 1'b1;
      lat_cnt    <= $urandom_range(0, lat_max);
      req_a      <= sram_addr;
      sram_rdata <= 16'($urandom);   // garbage until the access completes
    end else if (pend && !sram_dead) begin
      if (lat_cnt == 0) begin
        sram_ready <= 1'b1;
        sram_rdata <= mem[req_a];
        pend       <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // ---------------- downstream ready generator ----------------
  int rdy_mode = 0;       // 0: always 1, 1: toggle + one 5-cycle stall, 2: random
  int rdy_limit = 1000;   // force ready low once this many bytes are taken
  int stall_left = 0;
  bit stall_used = 1'b0;
  logic [7:0] got [$];

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       byte_ready = 1'b1;
      1:       byte_ready = ~byte_ready;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
    if (rdy_mode == 1 && !stall_used && got.size() == 3) begin
      stall_left = 5;
      stall_used = 1'b1;
    end
    if (stall_left > 0) begin
      byte_ready = 1'b0;
      stall_left--;
    end
    if (got.size() >= rdy_limit) byte_ready = 1'b0;
  end

  // ---------------- monitor ----------------
  logic [15:0] addrs [$];
  int   done_cnt, valid_cycles, busy_cycles, stab_viol;
  bit   hold_pend = 1'b0;
  logic [7:0] hold_data;

  always @(negedge clk) begin
    if (!reset) begin
      if (hold_pend && !(byte_valid && byte_data == hold_data)) stab_viol++;
      hold_pend = byte_valid && !byte_ready;
      hold_data = byte_data;
      if (byte_valid) valid_cycles++;
      if (byte_valid && byte_ready) got.push_back(byte_data);
      if (frame_done) done_cnt++;
      if (busy) busy_cycles++;
      if (!sram_start) addrs.push_back(sram_addr);
    end else begin
      hold_pend = 1'b0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0]  exp_bytes [$];
  logic [15:0] exp_addrs [$];
  int          exp_done;
  logic        exp_err;

  // The frame consists of every word from base up to and including the first
  // EOI word. If MAXW words pass without one, the readout ends in an error.
  task automatic build_exp(input logic [15:0] b);
    logic [15:0] a;
    logic [15:0] w;
    exp_bytes.delete();
    exp_addrs.delete();
    a = b;
    exp_done = 0;
    exp_err  = 1'b1;
    for (int n = 0; n < MAXW; n++) begin
      w = mem[a];
      exp_addrs.push_back(a);
      exp_bytes.push_back(w[7:0]);
      exp_bytes.push_back(w[15:8]);
      if (w == EOI) begin
        exp_done = 1;
        exp_err  = 1'b0;
        break;
      end
      a = a + 16'd1;
    end
  endtask

  function automatic int bytes_diff();
    int d;
    d = (got.size() != exp_bytes.size()) ? 1 : 0;
    for (int i = 0; i < got.size() && i < exp_bytes.size(); i++)
      if (got[i] !== exp_bytes[i]) d++;
    return d;
  endfunction

  function automatic int addrs_diff();
    int d;
    d = (addrs.size() != exp_addrs.size()) ? 1 : 0;
    for (int i = 0; i < addrs.size() && i < exp_addrs.size(); i++)
      if (addrs[i] !== exp_addrs[i]) d++;
    return d;
  endfunction

  task automatic launch(input logic [15:0] b);
    got.delete();
    addrs.delete();
    done_cnt = 0; valid_cycles = 0; busy_cycles = 0; stab_viol = 0;
    stall_used = 1'b0;
    base_addr = b;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, output bit to);
    to = 1'b1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic fill_frame(input logic [15:0] b, input int nwords, input bit with_eoi);
    for (int i = 0; i < nwords; i++)
      mem[16'(b + 16'(i))] = 16'($urandom) & 16'h7FFF;
    if (with_eoi) mem[16'(b + 16'(nwords - 1))] = EOI;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sram_addr, sram_start, sram_we, byte_data, byte_valid, busy, frame_done, error}
        !== {16'h0000, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_outputs addr=%h st=%b we=%b data=%h v=%b busy=%b done=%b err=%b, expected addr=0 st=1 we=1 data=0 rest 0",
               sram_addr, sram_start, sram_we, byte_data, byte_valid, busy, frame_done, error);
    end
    @(posedge clk); #1 reset = 1'b0;
    $display("test_reset: done");
  endtask

  task automatic test_basic();
    bit to;
    mem[16'h0010] = 16'h2211; mem[16'h0011] = 16'h4433; mem[16'h0012] = EOI;
    build_exp(16'h0010);
    rdy_mode = 0; lat_max = 0;
    launch(16'h0010);
    @(negedge clk);
    checks++;
    if (sram_start !== 1'b0 || sram_addr !== 16'h0010) begin
      errors++;
      $display("FAIL basic_req_latency sram_start=%b addr=%h, expected 0 and 0010", sram_start, sram_addr);
    end
    wait_idle(500, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout busy still 1, expected 0"); end
    checks++;
    if (bytes_diff() != 0) begin
      errors++; $display("FAIL basic_bytes got %0d bytes (%0d bad), expected %0d", got.size(), bytes_diff(), exp_bytes.size());
    end
    checks++; if (addrs_diff() != 0) begin errors++; $display("FAIL basic_addrs got %0d addrs, expected %0d", addrs.size(), exp_addrs.size()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done pulses=%0d, expected 1", done_cnt); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error got %b, expected 0", error); end
    checks++; if (busy_cycles != 18) begin errors++; $display("FAIL basic_throughput busy cycles=%0d, expected 18", busy_cycles); end
    $display("test_basic: %0d bytes, busy %0d cycles", got.size(), busy_cycles);
  endtask

  task automatic test_backpressure();
    bit to;
    mem[16'h0010] = 16'h2211; mem[16'h0011] = 16'h4433; mem[16'h0012] = EOI;
    build_exp(16'h0010);
    rdy_mode = 1; lat_max = 2;
    launch(16'h0010);
    wait_idle(1000, to);
    checks++; if (to) begin errors++; $display("FAIL bp_timeout busy still 1, expected 0"); end
    checks++;
    if (bytes_diff() != 0) begin
      errors++; $display("FAIL bp_bytes got %0d bytes (%0d bad), expected %0d", got.size(), bytes_diff(), exp_bytes.size());
    end
    checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable violations=%0d, expected 0", stab_viol); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done pulses=%0d, expected 1", done_cnt); end
    checks++; if (!stall_used) begin errors++; $display("FAIL bp_stall stall applied=0, expected 1"); end
    $display("test_backpressure: %0d bytes, valid cycles %0d", got.size(), valid_cycles);
  endtask

  task automatic test_timeout();
    bit to;
    mem[16'h0200] = 16'h1234; mem[16'h0201] = EOI;
    rdy_mode = 0; lat_max = 0; sram_dead = 1'b1;
    launch(16'h0200);
    repeat (200) @(negedge clk);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL to_early err=%b busy=%b at 200 cycles, expected 0 and 1", error, busy);
    end
    wait_idle(400, to);
    checks++; if (to) begin errors++; $display("FAIL to_bound busy still 1, expected 0"); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error got %b, expected 1", error); end
    checks++;
    if (busy_cycles < 255 || busy_cycles > 258) begin
      errors++; $display("FAIL to_duration busy cycles=%0d, expected 255..258", busy_cycles);
    end
    checks++;
    if (done_cnt != 0 || valid_cycles != 0) begin
      errors++; $display("FAIL to_quiet done=%0d valid=%0d, expected 0 and 0", done_cnt, valid_cycles);
    end
    sram_dead = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_sticky got %b, expected 1", error); end
    build_exp(16'h0200);
    launch(16'h0200);
    @(negedge clk);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_clear got %b, expected 0", error); end
    wait_idle(500, to);
    checks++;
    if (to || bytes_diff() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL to_recover timeout=%b bytes=%0d done=%0d, expected 0,%0d,1", to, got.size(), done_cnt, exp_bytes.size());
    end
    $display("test_timeout: error after %0d busy cycles, recovered", busy_cycles);
  endtask

  task automatic test_wrap();
    bit to;
    mem[16'hFFFF] = 16'hAABB; mem[16'h0000] = EOI;
    build_exp(16'hFFFF);
    rdy_mode = 2; lat_max = 3;
    launch(16'hFFFF);
    wait_idle(1000, to);
    checks++; if (to) begin errors++; $display("FAIL wrap_timeout busy still 1, expected 0"); end
    checks++;
    if (bytes_diff() != 0) begin
      errors++; $display("FAIL wrap_bytes got %0d bytes (%0d bad), expected BB AA D9 FF", got.size(), bytes_diff());
    end
    checks++;
    if (addrs_diff() != 0) begin
      errors++; $display("FAIL wrap_addrs got %0d addrs (last %h), expected FFFF,0000", addrs.size(), addrs.size() ? addrs[addrs.size()-1] : 16'h0);
    end
    $display("test_wrap: %0d bytes", got.size());
  endtask

  task automatic test_reset_midframe();
    bit to;
    bit seen;
    mem[16'h0300] = 16'h5A6B; mem[16'h0301] = EOI;
    rdy_mode = 0; lat_max = 1; rdy_limit = 1;
    launch(16'h0300);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (got.size() >= 1) begin seen = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!seen || byte_valid !== 1'b1 || byte_data !== 8'h5A) begin
      errors++; $display("FAIL rst_setup seen=%b valid=%b data=%h, expected 1 1 5a", seen, byte_valid, byte_data);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    rdy_limit = 1000;
    @(negedge clk);
    checks++;
    if ({sram_addr, sram_start, byte_data, byte_valid, busy, frame_done, error}
        !== {16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_outputs addr=%h st=%b data=%h v=%b busy=%b done=%b err=%b, expected reset values",
               sram_addr, sram_start, byte_data, byte_valid, busy, frame_done, error);
    end
    build_exp(16'h0300);
    launch(16'h0300);
    wait_idle(500, to);
    checks++;
    if (to || bytes_diff() != 0 || addrs_diff() != 0 || done_cnt != 1) begin
      errors++; $display("FAIL rst_refetch timeout=%b bytes=%0d done=%0d, expected 0,%0d,1", to, got.size(), done_cnt, exp_bytes.size());
    end
    $display("test_reset_midframe: refetched %0d bytes", got.size());
  endtask

  task automatic test_overrun();
    bit to;
    fill_frame(16'h0400, 6, 1'b0);
    build_exp(16'h0400);
    rdy_mode = 0; lat_max = 1;
    launch(16'h0400);
    wait_idle(1000, to);
    checks++; if (to) begin errors++; $display("FAIL ovr_timeout busy still 1, expected 0"); end
    checks++;
    if (got.size() != 8 || bytes_diff() != 0) begin
      errors++; $display("FAIL ovr_bytes got %0d bytes (%0d bad), expected 8", got.size(), bytes_diff());
    end
    checks++;
    if (error !== 1'b1 || done_cnt != 0) begin
      errors++; $display("FAIL ovr_error err=%b done=%0d, expected 1 and 0", error, done_cnt);
    end
    // An EOI as the last allowed word still completes normally.
    fill_frame(16'h0500, MAXW, 1'b1);
    build_exp(16'h0500);
    launch(16'h0500);
    wait_idle(1000, to);
    checks++;
    if (to || bytes_diff() != 0 || error !== 1'b0 || done_cnt != 1) begin
      errors++; $display("FAIL ovr_edge timeout=%b bytes=%0d err=%b done=%0d, expected 0,8,0,1", to, got.size(), error, done_cnt);
    end
    $display("test_overrun: error=%b", error);
  endtask

  task automatic test_random_frames();
    bit to;
    logic [15:0] b;
    int n;
    for (int it = 0; it < 10; it++) begin
      b = 16'($urandom);
      n = $urandom_range(1, MAXW + 1);
      fill_frame(b, n, (n <= MAXW));
      build_exp(b);
      rdy_mode = $urandom_range(0, 2);
      lat_max = $urandom_range(0, 3);
      launch(b);
      wait_idle(2000, to);
      checks++;
      if (to || bytes_diff() != 0 || addrs_diff() != 0) begin
        errors++; $display("FAIL rnd%0d_stream timeout=%b bytes=%0d (%0d bad), expected %0d", it, to, got.size(), bytes_diff(), exp_bytes.size());
      end
      checks++;
      if (done_cnt != exp_done || error !== exp_err || stab_viol != 0) begin
        errors++; $display("FAIL rnd%0d_status done=%0d err=%b stab=%0d, expected %0d %b 0", it, done_cnt, error, stab_viol, exp_done, exp_err);
      end
      $display("test_random_frames[%0d]: base=%h words=%0d mode=%0d bytes=%0d err=%b", it, b, n, rdy_mode, got.size(), error);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom) & 16'h7FFF;
    test_reset();
    test_basic();
    test_backpressure();
    test_timeout();
    test_wrap();
    test_reset_midframe();
    test_overrun();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
